// File: rtl/clock_pkg.sv
// clock_pkg: shared types, field ranges, reset defaults and calendar helpers
// for the clock datapath.
package clock_pkg;

    typedef enum logic [2:0] {
        F_YEAR  = 3'd0,
        F_MONTH = 3'd1,
        F_DAY   = 3'd2,
        F_HOUR  = 3'd3,
        F_MIN   = 3'd4,
        F_SEC   = 3'd5
    } field_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDIT,
        S_COMMIT
    } state_e;

    // Bit positions of the buttons inside the packed button/event vector.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_MID   = 4;

    localparam logic [14:0] YEAR_MIN  = 15'd1;
    localparam logic [14:0] YEAR_MAX  = 15'd9999;
    localparam logic [3:0]  MONTH_MIN = 4'd1;
    localparam logic [3:0]  MONTH_MAX = 4'd12;
    localparam logic [4:0]  DAY_MIN   = 5'd1;
    localparam logic [5:0]  HOUR_MAX  = 6'd23;
    localparam logic [5:0]  MIN_MAX   = 6'd59;
    localparam logic [5:0]  SEC_MAX   = 6'd59;

    localparam logic [14:0] RST_YEAR  = 15'd2000;
    localparam logic [3:0]  RST_MONTH = 4'd1;
    localparam logic [4:0]  RST_DAY   = 5'd1;
    localparam logic [5:0]  RST_HMS   = 6'd0;

    function automatic logic [4:0] days_in_month(input logic [14:0] year, input logic [3:0] month);
        logic leap;
        leap = ((year % 15'd4 == '0) && (year % 15'd100 != '0)) || (year % 15'd400 == '0);
        return (month == 4'd2) ? (leap ? 5'd29 : 5'd28) :
               (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    // +1/-1 step of a 0..max field with wrap in both directions.
    function automatic logic [5:0] wrap_step6(input logic [5:0] v, input logic [5:0] max, input logic inc);
        return inc ? ((v >= max) ? 6'd0 : v + 6'd1) : ((v == 6'd0) ? max : v - 6'd1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// btn_edge: registered rising-edge detector for the five buttons, with
// post-reset arm masking and optional up/down auto-repeat.
// Ports: clk, rst (async, active high), en (auto-repeat allowed, i.e. editing),
//        btn[4:0] button levels, ev[4:0] one-cycle event pulses.
// Build option: TIME_SET_AUTOREPEAT_EN adds the auto-repeat counter.
import clock_pkg::*;

module btn_edge #(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] btn,
    output logic [4:0] ev
);

    logic [4:0] btn_q;
    logic       arm;
    logic [4:0] edge_ev;

    // btn_q restarts from 0 after reset, so a button held through reset would
    // look like a fresh press on the first edge; arm suppresses that edge.
    assign edge_ev = btn & ~btn_q & {5{arm}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= '0;
            arm   <= 1'b0;
        end else begin
            btn_q <= btn;
            arm   <= 1'b1;
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    logic [31:0] cnt;
    logic        rep_on;
    logic        held;
    logic        fire;
    logic [4:0]  rep_ev;

    assign held = en & (btn[BTN_UP] | btn[BTN_DOWN]);
    assign fire = held && (edge_ev == '0) && (cnt == (rep_on ? REPEAT_RATE - 1 : REPEAT_DELAY - 1));

    always_comb begin
        rep_ev           = '0;
        rep_ev[BTN_UP]   = fire & btn[BTN_UP];
        rep_ev[BTN_DOWN] = fire & ~btn[BTN_UP];
    end

    // rep_on selects the first-delay vs. steady-rate interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            rep_on <= 1'b0;
        end else if (!held || edge_ev != '0 || fire) begin
            cnt    <= '0;
            rep_on <= fire;
        end else begin
            cnt    <= cnt + 32'd1;
        end
    end

    assign ev = edge_ev | rep_ev;
`else
    localparam int unsigned unused_rep = REPEAT_DELAY + REPEAT_RATE;
    logic unused_en;
    assign unused_en = en;
    assign ev = edge_ev;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time-setting controller; snapshots the live
// time, edits one field at a time and commits with a one-cycle load strobe.
// Ports: clk, rst (async, active high); up/down/left/right/middle buttons;
//        cur_* live time in; *_d edited time out; load commit strobe;
//        editing high while editing; field selected field (0=year..5=sec).
// Build option: TIME_SET_AUTOREPEAT_EN enables up/down auto-repeat.
import clock_pkg::*;

module time_set_ctrl #(
    parameter int unsigned TIMEOUT      = 1_000_000_000,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        middle,
    input  logic [14:0] cur_year,
    input  logic [3:0]  cur_month,
    input  logic [4:0]  cur_day,
    input  logic [5:0]  cur_hour,
    input  logic [5:0]  cur_min,
    input  logic [5:0]  cur_sec,
    output logic [14:0] year_d,
    output logic [3:0]  month_d,
    output logic [4:0]  day_d,
    output logic [5:0]  hour_d,
    output logic [5:0]  min_d,
    output logic [5:0]  sec_d,
    output logic        load,
    output logic        editing,
    output logic [2:0]  field
);

    state_e      state;
    logic [31:0] tcnt;
    logic [4:0]  ev;
    logic        inc;
    logic [14:0] yr_s;
    logic [3:0]  mo_s;
    logic [4:0]  dy_s, dim_c, dim_y, dim_m;

    btn_edge #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_btn (
        .clk(clk),
        .rst(rst),
        .en (editing),
        .btn({middle, right, left, down, up}),
        .ev (ev)
    );

    // Candidate stepped values; dim_y/dim_m give the month length after a
    // year/month step so day can be clamped in the same edge.
    always_comb begin
        inc   = ev[BTN_UP];
        dim_c = days_in_month(year_d, month_d);
        yr_s  = inc ? ((year_d >= YEAR_MAX) ? YEAR_MIN : year_d + 15'd1)
                    : ((year_d <= YEAR_MIN) ? YEAR_MAX : year_d - 15'd1);
        mo_s  = inc ? ((month_d >= MONTH_MAX) ? MONTH_MIN : month_d + 4'd1)
                    : ((month_d <= MONTH_MIN) ? MONTH_MAX : month_d - 4'd1);
        dy_s  = inc ? ((day_d >= dim_c) ? DAY_MIN : day_d + 5'd1)
                    : ((day_d <= DAY_MIN) ? dim_c : day_d - 5'd1);
        dim_y = days_in_month(yr_s, month_d);
        dim_m = days_in_month(year_d, mo_s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            load    <= 1'b0;
            editing <= 1'b0;
            field   <= F_YEAR;
            tcnt    <= '0;
            year_d  <= RST_YEAR;
            month_d <= RST_MONTH;
            day_d   <= RST_DAY;
            hour_d  <= RST_HMS;
            min_d   <= RST_HMS;
            sec_d   <= RST_HMS;
        end else begin
            load <= 1'b0;
            case (state)
                S_IDLE: if (ev[BTN_MID]) begin
                    year_d  <= cur_year;
                    month_d <= cur_month;
                    day_d   <= cur_day;
                    hour_d  <= cur_hour;
                    min_d   <= cur_min;
                    sec_d   <= cur_sec;
                    field   <= F_YEAR;
                    tcnt    <= '0;
                    editing <= 1'b1;
                    state   <= S_EDIT;
                end
                S_EDIT: begin
                    tcnt <= (ev != '0) ? '0 : tcnt + 32'd1;
                    if (ev[BTN_MID]) begin
                        load    <= 1'b1;
                        editing <= 1'b0;
                        state   <= S_COMMIT;
                    end else if (ev[BTN_LEFT]) begin
                        field <= (field == F_YEAR) ? F_SEC : field - 3'd1;
                    end else if (ev[BTN_RIGHT]) begin
                        field <= (field == F_SEC) ? F_YEAR : field + 3'd1;
                    end else if (ev[BTN_UP] | ev[BTN_DOWN]) begin
                        case (field)
                            F_YEAR: begin
                                year_d <= yr_s;
                                day_d  <= (day_d > dim_y) ? dim_y : day_d;
                            end
                            F_MONTH: begin
                                month_d <= mo_s;
                                day_d   <= (day_d > dim_m) ? dim_m : day_d;
                            end
                            F_DAY:   day_d  <= dy_s;
                            F_HOUR:  hour_d <= wrap_step6(hour_d, HOUR_MAX, inc);
                            F_MIN:   min_d  <= wrap_step6(min_d, MIN_MAX, inc);
                            default: sec_d  <= wrap_step6(sec_d, SEC_MAX, inc);
                        endcase
                    end else if (TIMEOUT != 0 && tcnt + 32'd1 >= TIMEOUT) begin
                        editing <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and randomized checks of time_set_ctrl against a
// calendar-level reference model.
module tb_time_set_ctrl;

    localparam int B_UP = 1, B_DN = 2, B_LT = 4, B_RT = 8, B_MD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        up, down, left, right, middle;
    logic [14:0] cur_year;
    logic [3:0]  cur_month;
    logic [4:0]  cur_day;
    logic [5:0]  cur_hour, cur_min, cur_sec;
    logic [14:0] year_d;
    logic [3:0]  month_d;
    logic [4:0]  day_d;
    logic [5:0]  hour_d, min_d, sec_d;
    logic        load, editing;
    logic [2:0]  field;

    int total = 0;
    int bad   = 0;

    int my, mmo, md, mh, mmi, ms, mf;
    bit med, mload;

    time_set_ctrl #(.TIMEOUT(20), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
        .clk(clk), .rst(rst),
        .up(up), .down(down), .left(left), .right(right), .middle(middle),
        .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .year_d(year_d), .month_d(month_d), .day_d(day_d),
        .hour_d(hour_d), .min_d(min_d), .sec_d(sec_d),
        .load(load), .editing(editing), .field(field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dim(input int y, input int m);
        bit leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        if (m == 2) return leap ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic int wrap(input int v, input int lo, input int hi);
        return (v > hi) ? lo : (v < lo) ? hi : v;
    endfunction

    task automatic model_reset();
        my = 2000; mmo = 1; md = 1; mh = 0; mmi = 0; ms = 0;
        mf = 0; med = 0; mload = 0;
    endtask

    task automatic model_step(input int dir);
        case (mf)
            0: begin my  = wrap(my + dir, 1, 9999); if (md > dim(my, mmo)) md = dim(my, mmo); end
            1: begin mmo = wrap(mmo + dir, 1, 12);  if (md > dim(my, mmo)) md = dim(my, mmo); end
            2: md  = wrap(md + dir, 1, dim(my, mmo));
            3: mh  = wrap(mh + dir, 0, 23);
            4: mmi = wrap(mmi + dir, 0, 59);
            default: ms = wrap(ms + dir, 0, 59);
        endcase
    endtask

    task automatic model_event(input int b);
        mload = 0;
        if (!med) begin
            if ((b & B_MD) != 0) begin
                my = int'(cur_year); mmo = int'(cur_month); md = int'(cur_day);
                mh = int'(cur_hour); mmi = int'(cur_min); ms = int'(cur_sec);
                mf = 0; med = 1;
            end
        end else if ((b & B_MD) != 0) begin
            med = 0; mload = 1;
        end else if ((b & B_LT) != 0) mf = (mf + 5) % 6;
        else if ((b & B_RT) != 0) mf = (mf + 1) % 6;
        else if ((b & B_UP) != 0) model_step(1);
        else if ((b & B_DN) != 0) model_step(-1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " year"},    int'(year_d),  my);
        chk({tag, " month"},   int'(month_d), mmo);
        chk({tag, " day"},     int'(day_d),   md);
        chk({tag, " hour"},    int'(hour_d),  mh);
        chk({tag, " min"},     int'(min_d),   mmi);
        chk({tag, " sec"},     int'(sec_d),   ms);
        chk({tag, " field"},   int'(field),   mf);
        chk({tag, " editing"}, int'(editing), int'(med));
        chk({tag, " load"},    int'(load),    int'(mload));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b);
        {middle, right, left, down, up} = 5'(b);
    endtask

    task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
        cur_year = 15'(y); cur_month = 4'(mo); cur_day = 5'(d);
        cur_hour = 6'(h);  cur_min = 6'(mi);   cur_sec = 6'(s);
    endtask

    task automatic press(input string tag, input int b);
        set_btn(b);
        tick();
        model_event(b);
        check_all({tag, " press"});
        set_btn(0);
        tick();
        mload = 0;
        check_all({tag, " release"});
    endtask

    initial begin
        int y, mo, steps, b;
        rst = 1'b1;
        set_btn(0);
        set_cur(2023, 12, 31, 23, 59, 59);
        model_reset();
        repeat (3) tick();
        check_all("reset");
        rst = 1'b0;
        tick();
        check_all("post reset");

        press("snapshot", B_MD);
        chk("snapshot year const", int'(year_d), 2023);
        repeat (4) press("right", B_RT);
        press("min wrap", B_UP);
        chk("min wrap const", int'(min_d), 0);
        chk("no carry hour", int'(hour_d), 23);
        press("commit", B_MD);
        repeat (3) tick();
        check_all("held after commit");

        set_cur(2024, 3, 31, 12, 0, 0);
        press("snap2", B_MD);
        press("to month", B_RT);
        press("month down", B_DN);
        chk("feb leap day", int'(day_d), 29);
        press("to year", B_LT);
        press("year down", B_DN);
        chk("feb nonleap day", int'(day_d), 28);
        press("left wrap", B_LT);
        chk("left wrap field", int'(field), 5);
        press("mid+up", B_MD | B_UP);

        press("to edit", B_MD);
        repeat (18) begin
            tick();
            chk("timeout load", int'(load), 0);
        end
        chk("before timeout", int'(editing), 1);
        tick();
        med = 0;
        check_all("timeout");

        press("edit again", B_MD);
        press("edit right", B_RT);
        #1;
        rst = 1'b1;
        set_btn(B_MD | B_UP);
        #2;
        model_reset();
        check_all("async reset");
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_all("held through reset");
        set_btn(0);
        tick();
        press("repress", B_MD);

        set_cur(2024, 5, 10, 22, 10, 10);
        press("commit0", B_MD);
        press("snap3", B_MD);
        repeat (3) press("to hour", B_RT);
        set_btn(B_UP);
        repeat (10) tick();
        set_btn(0);
        tick();
`ifdef TIME_SET_AUTOREPEAT_EN
        steps = 4;
`else
        steps = 1;
`endif
        repeat (steps) model_step(1);
        check_all("hold up");
        chk("hold up hour", int'(hour_d), (steps == 4) ? 2 : 23);
        repeat (3) tick();
        check_all("after hold");
        press("commit hold", B_MD);

        repeat (150) begin
            y  = $urandom_range(1, 9999);
            mo = $urandom_range(1, 12);
            set_cur(y, mo, $urandom_range(1, dim(y, mo)), $urandom_range(0, 23),
                    $urandom_range(0, 59), $urandom_range(0, 59));
            b = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) b = b | B_MD;
            if (b == 0) b = B_UP;
            press("random", b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
